// File: rtl/tpu_host_ctrl.sv
// Host-side command-to-bus initiator for the TPU memory-mapped port.
// Optional busy-cycle counter enabled by defining TPU_HOST_PERF_CNT_EN.
module tpu_host_ctrl #(
    parameter int BITS_AB    = 8,
    parameter int BITS_C     = 16,
    parameter int DIM        = 8,
    parameter int ADDRW      = 16,
    parameter int DATAW      = 64,
    parameter int RD_LAT     = 1,
    parameter int MUL_CYCLES = 22
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [1:0]             cmd_op,
    input  logic [$clog2(DIM)-1:0] cmd_row,
    input  logic [DATAW-1:0]       cmd_data,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [2*DATAW-1:0]     rsp_data,
    output logic                   mul_done,
    output logic                   tpu_en,
    output logic                   r_w,
    output logic [ADDRW-1:0]       addr,
    output logic [DATAW-1:0]       dataIn,
    input  logic [DATAW-1:0]       dataOut,
    output logic [31:0]            busy_cycles
);

    localparam int RW      = $clog2(DIM);
    localparam int CNT_MAX = (MUL_CYCLES > RD_LAT) ? MUL_CYCLES : RD_LAT;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] MUL_LAST = CW'(MUL_CYCLES - 1);
    localparam logic [CW-1:0] RD_LAST  = CW'(RD_LAT - 1);

    localparam logic [ADDRW-1:0] A_BASE = ADDRW'(16'h0100);
    localparam logic [ADDRW-1:0] B_BASE = ADDRW'(16'h0200);
    localparam logic [ADDRW-1:0] C_BASE = ADDRW'(16'h0300);
    localparam logic [ADDRW-1:0] M_ADDR = ADDRW'(16'h0400);

    localparam logic [1:0] OP_LOAD_A = 2'd0;
    localparam logic [1:0] OP_LOAD_B = 2'd1;
    localparam logic [1:0] OP_MULT   = 2'd2;
    localparam logic [1:0] OP_READ_C = 2'd3;

    // A row and a C half-row must both fill exactly one bus word.
    if (DATAW != DIM * BITS_AB || 2 * DATAW != DIM * BITS_C) begin : g_bad_width
        $error("tpu_host_ctrl: DATAW must equal DIM*BITS_AB and DIM*BITS_C/2");
    end

    if (RD_LAT < 1 || MUL_CYCLES < 1) begin : g_bad_lat
        $error("tpu_host_ctrl: RD_LAT and MUL_CYCLES must be >= 1");
    end

    typedef enum logic [2:0] {
        IDLE,
        WR,
        MUL_WAIT,
        RD_ISSUE0,
        RD_WAIT0,
        RD_ISSUE1,
        RD_WAIT1,
        RSP
    } state_t;

    state_t             state, state_n;
    logic [CW-1:0]      cnt, cnt_n;
    logic               is_mult, is_mult_n;
    logic [RW-1:0]      row_q, row_n;
    logic               en_n, rw_n;
    logic [ADDRW-1:0]   addr_n;
    logic [DATAW-1:0]   din_n;
    logic [2*DATAW-1:0] rsp_n;

    assign cmd_ready = (state == IDLE);
    assign rsp_valid = (state == RSP);
    assign mul_done  = (state == MUL_WAIT) && (cnt == MUL_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            is_mult  <= 1'b0;
            row_q    <= '0;
            tpu_en   <= 1'b0;
            r_w      <= 1'b0;
            addr     <= '0;
            dataIn   <= '0;
            rsp_data <= '0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            is_mult  <= is_mult_n;
            row_q    <= row_n;
            tpu_en   <= en_n;
            r_w      <= rw_n;
            addr     <= addr_n;
            dataIn   <= din_n;
            rsp_data <= rsp_n;
        end
    end

    // Next-state logic also computes the registered bus values for the
    // following cycle, so tpu_en rises exactly in the cycle of the access.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        is_mult_n = is_mult;
        row_n     = row_q;
        en_n      = 1'b0;
        rw_n      = r_w;
        addr_n    = addr;
        din_n     = dataIn;
        rsp_n     = rsp_data;

        unique case (state)
            IDLE: begin
                if (cmd_valid) begin
                    row_n     = cmd_row;
                    en_n      = 1'b1;
                    is_mult_n = 1'b0;
                    unique case (cmd_op)
                        OP_LOAD_A: begin
                            state_n = WR;
                            rw_n    = 1'b1;
                            addr_n  = A_BASE + ADDRW'(cmd_row);
                            din_n   = cmd_data;
                        end
                        OP_LOAD_B: begin
                            state_n = WR;
                            rw_n    = 1'b1;
                            addr_n  = B_BASE + ADDRW'(cmd_row);
                            din_n   = cmd_data;
                        end
                        OP_MULT: begin
                            state_n   = WR;
                            is_mult_n = 1'b1;
                            rw_n      = 1'b1;
                            addr_n    = M_ADDR;
                            din_n     = '0;
                        end
                        OP_READ_C: begin
                            state_n = RD_ISSUE0;
                            rw_n    = 1'b0;
                            addr_n  = C_BASE + ADDRW'({cmd_row, 1'b0});
                        end
                        default: ;
                    endcase
                end
            end
            WR: begin
                cnt_n   = '0;
                state_n = is_mult ? MUL_WAIT : IDLE;
            end
            MUL_WAIT: begin
                if (cnt == MUL_LAST) begin
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            RD_ISSUE0: begin
                cnt_n   = '0;
                state_n = RD_WAIT0;
            end
            RD_WAIT0: begin
                if (cnt == RD_LAST) begin
                    rsp_n[DATAW-1:0] = dataOut;
                    state_n = RD_ISSUE1;
                    en_n    = 1'b1;
                    addr_n  = C_BASE + ADDRW'({row_q, 1'b1});
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            RD_ISSUE1: begin
                cnt_n   = '0;
                state_n = RD_WAIT1;
            end
            RD_WAIT1: begin
                if (cnt == RD_LAST) begin
                    rsp_n[2*DATAW-1:DATAW] = dataOut;
                    state_n = RSP;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            RSP: begin
                if (rsp_ready) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

`ifdef TPU_HOST_PERF_CNT_EN
    logic [31:0] busy_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else if (state != IDLE && busy_q != 32'hFFFF_FFFF) begin
            busy_q <= busy_q + 32'd1;
        end
    end

    assign busy_cycles = busy_q;
`else
    assign busy_cycles = '0;
`endif

endmodule
